// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point streaming FFT input stage: frame geometry,
// packed complex sample layout and the read-side FSM state type.
package fft_pkg;

  localparam int DATA_W = 34;
  localparam int N      = 16;
  localparam int LOG2N  = 4;

  // Per-component fixed-point layout: {sign, integer, fraction}
  localparam int SIGN_W = 1;
  localparam int INT_W  = 8;
  localparam int FRAC_W = 8;
  localparam int COMP_W = SIGN_W + INT_W + FRAC_W;

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

endpackage

// File: rtl/fft_pingpong_mem.sv
// Two-bank frame buffer: 2*N x DATA_W registers, one synchronous write port and
// one combinational read port, both addressed by {bank, idx}.
module fft_pingpong_mem
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2N:0]    wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LOG2N:0]    rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2*N];

  // NOTE: storage is deliberately not reset; the full flags guard every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_in_framer.sv
// Ping-pong frame buffer feeding the FFT core with gap-free N-sample frames.
// Optional short-frame zero padding is enabled by defining FFT_FRAMER_ZPAD_EN.
module fft_in_framer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_valid,
  output logic              fft_sof,
  output logic [LOG2N-1:0]  fft_index
);

  logic              wr_bank;
  logic              rd_bank;
  logic              rd_bank_nxt;
  logic [LOG2N-1:0]  wr_cnt;
  logic [LOG2N-1:0]  rd_cnt;
  logic [LOG2N-1:0]  rd_cnt_nxt;
  logic [LOG2N-1:0]  rd_idx;
  logic [1:0]        full;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic              accept;
  logic              close_req;
  logic              close_rd;
  logic              clr_rd;
  logic              pad;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] sample0;
  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              sof_nxt;
  logic [LOG2N-1:0]  index_nxt;

  assign s_ready = !rst && !full[wr_bank];
  assign accept  = s_valid && s_ready;

`ifdef FFT_FRAMER_ZPAD_EN
  logic [LOG2N-1:0] last_idx [2];

  assign close_req = accept && ((wr_cnt == IDX_LAST) || s_last);

  always_ff @(posedge clk) begin
    if (close_req) last_idx[wr_bank] <= wr_cnt;
  end

  assign pad = (rd_cnt > last_idx[rd_bank]);
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign close_req     = accept && (wr_cnt == IDX_LAST);
  assign pad           = 1'b0;
`endif

  // A bank closing this edge can start streaming on the same edge; only a
  // one-sample frame needs its sample 0 taken straight from the input.
  assign close_rd = close_req && (wr_bank == rd_bank);
  assign sample0  = (close_rd && (wr_cnt == '0)) ? s_data : rd_data;
  assign rd_idx   = (state == RD_STREAM) ? rd_cnt : '0;

  fft_pingpong_mem u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data (s_data),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    clr_rd      = 1'b0;
    valid_nxt   = 1'b0;
    sof_nxt     = 1'b0;
    index_nxt   = '0;
    data_nxt    = '0;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank] || close_rd) begin
          valid_nxt  = 1'b1;
          sof_nxt    = 1'b1;
          data_nxt   = sample0;
          rd_cnt_nxt = LOG2N'(1);
          state_nxt  = RD_STREAM;
        end
      end
      RD_STREAM: begin
        valid_nxt  = 1'b1;
        index_nxt  = rd_cnt;
        data_nxt   = pad ? '0 : rd_data;
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (rd_cnt == IDX_LAST) begin
          clr_rd      = 1'b1;
          rd_bank_nxt = ~rd_bank;
          state_nxt   = RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign full_set = close_req ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = clr_rd    ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      full      <= 2'b00;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      state     <= RD_IDLE;
      fft_data  <= '0;
      fft_valid <= 1'b0;
      fft_sof   <= 1'b0;
      fft_index <= '0;
    end else begin
      if (accept) begin
        wr_cnt <= close_req ? '0 : wr_cnt + 1'b1;
        if (close_req) wr_bank <= ~wr_bank;
      end
      full      <= (full & ~full_clr) | full_set;
      rd_bank   <= rd_bank_nxt;
      rd_cnt    <= rd_cnt_nxt;
      state     <= state_nxt;
      fft_data  <= data_nxt;
      fft_valid <= valid_nxt;
      fft_sof   <= sof_nxt;
      fft_index <= index_nxt;
    end
  end

endmodule

// File: tb/tb_fft_in_framer.sv
// Scoreboard bench for fft_in_framer: accepted samples queue their expected
// outputs; a negedge monitor pops and compares every valid output sample.
module tb_fft_in_framer;
  import fft_pkg::*;

`ifdef FFT_FRAMER_ZPAD_EN
  localparam bit ZPAD = 1'b1;
`else
  localparam bit ZPAD = 1'b0;
`endif

  typedef struct packed {
    logic              sof;
    logic [LOG2N-1:0]  idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic [DATA_W-1:0] fft_data;
  logic              fft_valid;
  logic              fft_sof;
  logic [LOG2N-1:0]  fft_index;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_model = 0;
  int   popped = 0;
  int   valid_run = 0;
  int   max_run = 0;
  int   nr_run = 0;
  int   max_nr_run = 0;
  bit   in_frame = 1'b0;

  fft_in_framer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .fft_data  (fft_data),
    .fft_valid (fft_valid),
    .fft_sof   (fft_sof),
    .fft_index (fft_index)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input bit last);
    exp_q.push_back('{sof: (wr_model == 0), idx: LOG2N'(wr_model), data: d});
    if (ZPAD && last && wr_model < N - 1) begin
      for (int k = wr_model + 1; k < N; k++)
        exp_q.push_back('{sof: 1'b0, idx: LOG2N'(k), data: '0});
      wr_model = 0;
    end else begin
      wr_model = (wr_model + 1) % N;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [DATA_W-1:0] d, input bit last);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 100 && !ok; t++) begin
      ok = s_ready;
      @(posedge clk);
      if (ok) push_exp(d, last);
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 64'(s_ready), 64'd1);
    s_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    s_valid = 1'b0;
    while ((exp_q.size() != 0 || in_frame || fft_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_q.delete();
    wr_model = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(fft_valid), 64'd0);
    check("rst_sof",   64'(fft_sof),   64'd0);
    check("rst_index", 64'(fft_index), 64'd0);
    check("rst_data",  64'(fft_data),  64'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      valid_run = 0;
      nr_run    = 0;
    end else begin
      if (in_frame) check("no_gap", 64'(fft_valid), 64'd1);
      if (fft_valid) begin
        valid_run++;
        if (valid_run > max_run) max_run = valid_run;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(fft_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", 64'({fft_sof, fft_index, fft_data}), 64'(mon_e));
          popped++;
        end
        in_frame = (fft_index != IDX_LAST);
      end else begin
        valid_run = 0;
        in_frame  = 1'b0;
      end
      if (!s_ready) begin
        nr_run++;
        if (nr_run > max_nr_run) max_nr_run = nr_run;
      end else begin
        nr_run = 0;
      end
    end
  end

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    check("init_valid", 64'(fft_valid), 64'd0);
    check("init_sof",   64'(fft_sof),   64'd0);
    check("init_index", 64'(fft_index), 64'd0);
    check("init_data",  64'(fft_data),  64'd0);
    check("init_ready", 64'(s_ready),   64'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // 1: single frame, latency of one cycle after the 16th accept
    max_run = 0;
    for (int i = 1; i <= 16; i++) begin
      send(DATA_W'(i), 1'b0);
      if (i == 15) check("t1_no_early", 64'(fft_valid), 64'd0);
      if (i == 16) check("t1_first", 64'({fft_valid, fft_sof, fft_index, fft_data}),
                         64'({1'b1, 1'b1, 4'd0, 34'h1}));
    end
    drain();
    check("t1_run", 64'(max_run), 64'd16);

    // 2: three frames back to back
    max_run = 0;
    max_nr_run = 0;
    for (int i = 0; i < 48; i++) send(DATA_W'(32'h100 + i), 1'b0);
    drain();
    check("t2_run", 64'(max_run), 64'd48);
    check("t2_ready_drop", 64'(max_nr_run > 1), 64'd0);

    // 3: two frames at full rate, a third with one-cycle gaps
    max_run = 0;
    for (int i = 0; i < 32; i++) send(DATA_W'(32'h200 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(DATA_W'(32'h220 + i), 1'b0);
      if (i == 14) check("t3_wait_valid", 64'(fft_valid), 64'd0);
      if (i == 15) check("t3_first", 64'({fft_valid, fft_sof, fft_data}),
                         64'({1'b1, 1'b1, 34'h220}));
      s_valid = 1'b0;
      @(negedge clk);
    end
    drain();
    check("t3_run", 64'(max_run), 64'd32);

    // 4a: reset during the write of sample 7
    for (int i = 0; i < 7; i++) send(DATA_W'(32'h300 + i), 1'b0);
    do_reset();
    check("t4_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 16; i++) send(DATA_W'(32'h310 + i), 1'b0);
    drain();

    // 4b: reset while output index 5 is presented
    for (int i = 0; i < 16; i++) send(DATA_W'(32'h320 + i), 1'b0);
    s_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (fft_valid && fft_index == 4'd5) break;
      @(negedge clk);
    end
    check("t4_saw_idx5", 64'(fft_index), 64'd5);
    do_reset();
    p0 = popped;
    for (int i = 0; i < 16; i++) send(DATA_W'(32'h330 + i), 1'b0);
    drain();
    check("t4_count", 64'(popped - p0), 64'd16);

    // 5: short frame terminated by s_last on the 5th sample
    p0 = popped;
    for (int i = 0; i < 5; i++) send(34'h2_AAAA_0000 + DATA_W'(i), i == 4);
    if (!ZPAD) begin
      s_valid = 1'b0;
      repeat (30) @(negedge clk);
      check("t5_no_output", 64'(popped - p0), 64'd0);
      for (int i = 5; i < 16; i++) send(34'h2_AAAA_0000 + DATA_W'(i), 1'b0);
    end
    drain();
    check("t5_count", 64'(popped - p0), 64'd16);

    // 6: long continuous stream using all data bits
    p0 = popped;
    for (int i = 0; i < 80; i++) send(34'h3_5A5A_0000 + DATA_W'(i * 32'h1_0101), 1'b0);
    drain();
    check("t6_count", 64'(popped - p0), 64'd80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
